// File: rtl/i2c_master_nco_writer.sv
// I2C single-master write engine that programs the NCO slave register block.
// Optional build macro I2C_NACK_RETRY_EN: a NACKed frame is restarted up to two more times.
module i2c_master_nco_writer #(
  parameter logic [6:0] SLAVE_ADDR = 7'b1101010,
  parameter int         CLK_DIV    = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [1:0]  mode,
  input  logic        enable_in,
  input  logic [1:0]  wave_in,
  input  logic [63:0] freq_in,
  input  logic [15:0] duty_in,
  output logic        ready,
  output logic        done,
  output logic        nack,
  output logic        scl,
  inout  wire         sda
);

  localparam int QW = $clog2(CLK_DIV);
  localparam logic [QW-1:0] Q_LAST = QW'(CLK_DIV - 1);
  localparam logic [7:0] ADDR_BYTE = {SLAVE_ADDR, 1'b0};

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_ADDR, S_ADDR_ACK, S_CTRL, S_CTRL_ACK,
    S_DATA, S_DATA_ACK, S_STOP, S_GAP
  } state_t;

  state_t        state, state_next;
  logic [QW-1:0] q_cnt;
  logic [1:0]    qtr;
  logic [2:0]    bit_cnt;
  logic [3:0]    byte_idx;
  logic [7:0]    ctrl_r;
  logic [63:0]   data_sr;
  logic          acked;
  logic          failed;
  logic          sda_low;
  logic          sda_in;
  logic          retry_go;

  logic q_last, bit_end, ack_sample, accept, ack_state, has_data, last_byte;

  assign sda        = sda_low ? 1'b0 : 1'bz;
  assign sda_in     = sda;
  assign ready      = (state == S_IDLE) && !done;
  assign accept     = start && ready;
  assign q_last     = (q_cnt == Q_LAST);
  assign bit_end    = q_last && (qtr == 2'd3);
  assign ack_sample = q_last && (qtr == 2'd2);
  assign ack_state  = (state == S_ADDR_ACK) || (state == S_CTRL_ACK) || (state == S_DATA_ACK);
  assign has_data   = ctrl_r[3] || ctrl_r[4];
  assign last_byte  = ctrl_r[3] ? (byte_idx == 4'd7) : (byte_idx == 4'd1);

`ifdef I2C_NACK_RETRY_EN
  logic [1:0] retry_cnt;

  assign retry_go = failed && (retry_cnt != 2'd2);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      retry_cnt <= 2'd0;
    else if (accept)
      retry_cnt <= 2'd0;
    else if ((state == S_STOP) && bit_end && retry_go)
      retry_cnt <= retry_cnt + 2'd1;
  end
`else
  assign retry_go = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      state <= S_IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    scl        = 1'b1;
    sda_low    = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) state_next = S_START;
      end
      S_START: begin
        sda_low = qtr[1];
        if (bit_end) state_next = S_ADDR;
      end
      S_ADDR: begin
        scl     = qtr[1];
        sda_low = ~ADDR_BYTE[bit_cnt];
        if (bit_end && (bit_cnt == 3'd0)) state_next = S_ADDR_ACK;
      end
      S_ADDR_ACK: begin
        scl = qtr[1];
        if (bit_end) state_next = acked ? S_CTRL : S_STOP;
      end
      S_CTRL: begin
        scl     = qtr[1];
        sda_low = ~ctrl_r[bit_cnt];
        if (bit_end && (bit_cnt == 3'd0)) state_next = S_CTRL_ACK;
      end
      S_CTRL_ACK: begin
        scl = qtr[1];
        if (bit_end) state_next = (acked && has_data) ? S_DATA : S_STOP;
      end
      S_DATA: begin
        scl     = qtr[1];
        // byte 0 lives in data_sr[63:56], so the byte index is inverted into the bit address
        sda_low = ~data_sr[{~byte_idx[2:0], bit_cnt}];
        if (bit_end && (bit_cnt == 3'd0)) state_next = S_DATA_ACK;
      end
      S_DATA_ACK: begin
        scl = qtr[1];
        if (bit_end) state_next = (!acked || last_byte) ? S_STOP : S_DATA;
      end
      S_STOP: begin
        scl     = qtr[1];
        sda_low = (qtr != 2'd3);
        if (bit_end) state_next = retry_go ? S_GAP : S_IDLE;
      end
      S_GAP: begin
        if (bit_end) state_next = S_START;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_cnt <= '0;
      qtr   <= 2'd0;
    end else if (state == S_IDLE) begin
      q_cnt <= '0;
      qtr   <= 2'd0;
    end else if (q_last) begin
      q_cnt <= '0;
      qtr   <= qtr + 2'd1;
    end else begin
      q_cnt <= q_cnt + 1'b1;
    end
  end

  // bit_cnt wraps 0 -> 7 at the end of each byte, ready for the next one
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt  <= 3'd0;
      byte_idx <= 4'd0;
    end else if (state == S_START) begin
      bit_cnt  <= 3'd7;
      byte_idx <= 4'd0;
    end else if (bit_end) begin
      if ((state == S_ADDR) || (state == S_CTRL) || (state == S_DATA))
        bit_cnt <= bit_cnt - 3'd1;
      if (state == S_DATA_ACK)
        byte_idx <= byte_idx + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_r  <= 8'h00;
      data_sr <= 64'h0;
      acked   <= 1'b0;
      failed  <= 1'b0;
      done    <= 1'b0;
      nack    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        ctrl_r  <= {3'b000, mode == 2'b10, mode == 2'b01, wave_in, enable_in};
        data_sr <= (mode == 2'b10) ? {duty_in, 48'h0} : freq_in;
        nack    <= 1'b0;
        failed  <= 1'b0;
      end
      if (ack_state && ack_sample)
        acked <= ~sda_in;
      if (ack_state && bit_end && !acked)
        failed <= 1'b1;
      if ((state == S_STOP) && bit_end) begin
        if (retry_go) begin
          failed <= 1'b0;
        end else begin
          done <= 1'b1;
          nack <= failed;
        end
      end
    end
  end

endmodule

// File: tb/tb_i2c_master_nco_writer.sv
// Scoreboard bench for i2c_master_nco_writer: a bus monitor/slave model pops expected
// START/byte/STOP tokens and done results pushed by a frame-level reference model.
module tb_i2c_master_nco_writer;

  localparam int CLK_DIV   = 4;
  localparam int BIT_CLK   = 4 * CLK_DIV;
  localparam int TOK_START = 256;
  localparam int TOK_STOP  = 257;
  localparam int WAIT_MAX  = 6000;
`ifdef I2C_NACK_RETRY_EN
  localparam int NACK_ATTEMPTS = 3;
`else
  localparam int NACK_ATTEMPTS = 1;
`endif

  typedef struct {
    int accept_cyc;
    int latency;
    bit nack;
  } done_exp_t;

  logic        clk       = 1'b0;
  logic        reset_n   = 1'b0;
  logic        start     = 1'b0;
  logic [1:0]  mode      = 2'b00;
  logic        enable_in = 1'b0;
  logic [1:0]  wave_in   = 2'b00;
  logic [63:0] freq_in   = 64'h0;
  logic [15:0] duty_in   = 16'h0;
  logic        ready, done, nack, scl;
  wire         sda_bus;
  logic        slave_low = 1'b0;

  pullup (sda_bus);
  assign sda_bus = slave_low ? 1'b0 : 1'bz;

  i2c_master_nco_writer #(.SLAVE_ADDR(7'b1101010), .CLK_DIV(CLK_DIV)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .mode(mode),
    .enable_in(enable_in), .wave_in(wave_in), .freq_in(freq_in), .duty_in(duty_in),
    .ready(ready), .done(done), .nack(nack), .scl(scl), .sda(sda_bus)
  );

  always #5 clk = ~clk;

  int        compared      = 0;
  int        mismatched    = 0;
  int        cyc           = 0;
  int        slave_nack_at = -1;
  bit        last_nack     = 1'b0;
  int        tok_q[$];
  done_exp_t done_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input longint actual, input longint expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic report_missing(input string name);
    compared++;
    mismatched++;
    $display("[TB] FAIL %s: actual=event required=none (t=%0t)", name, $time);
  endtask

  task automatic expect_tok(input int got);
    if (tok_q.size() == 0) report_missing("unexpected_bus_token");
    else check_output("bus_token", got, tok_q.pop_front());
  endtask

  // Frame-level reference: byte list, bus tokens per attempt, total bit times.
  task automatic push_model(input logic [1:0] m, input logic en, input logic [1:0] wv,
                            input logic [63:0] fr, input logic [15:0] dt,
                            input int nack_at, input int acc);
    int bytes[$];
    int sent, attempts, bits;
    done_exp_t e;
    bytes.push_back(int'(7'b1101010) * 2);
    bytes.push_back((m == 2'b10 ? 16 : 0) + (m == 2'b01 ? 8 : 0) + int'(wv) * 2 + int'(en));
    if (m == 2'b01)
      for (int i = 0; i < 8; i++) bytes.push_back(int'((fr >> (56 - 8 * i)) & 64'hFF));
    if (m == 2'b10) begin
      bytes.push_back(int'(dt[15:8]));
      bytes.push_back(int'(dt[7:0]));
    end
    if (nack_at >= 0 && nack_at < bytes.size()) begin
      attempts = NACK_ATTEMPTS;
      sent     = nack_at + 1;
      e.nack   = 1'b1;
    end else begin
      attempts = 1;
      sent     = bytes.size();
      e.nack   = 1'b0;
    end
    for (int a = 0; a < attempts; a++) begin
      tok_q.push_back(TOK_START);
      for (int i = 0; i < sent; i++) tok_q.push_back(bytes[i]);
      tok_q.push_back(TOK_STOP);
    end
    bits         = attempts * (2 + 9 * sent) + (attempts - 1);
    e.latency    = bits * BIT_CLK;
    e.accept_cyc = acc;
    done_q.push_back(e);
    last_nack = e.nack;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (ready !== 1'b1 && n < WAIT_MAX) begin
      @(negedge clk);
      n++;
    end
    if (ready !== 1'b1) report_missing("ready_timeout");
  endtask

  task automatic apply_stimulus(input logic [1:0] m, input logic en, input logic [1:0] wv,
                                input logic [63:0] fr, input logic [15:0] dt, input int nack_at);
    wait_ready();
    check_output("nack_held", nack, last_nack);
    slave_nack_at = nack_at;
    mode      = m;
    enable_in = en;
    wave_in   = wv;
    freq_in   = fr;
    duty_in   = dt;
    start     = 1'b1;
    push_model(m, en, wv, fr, dt, nack_at, cyc + 1);
    @(negedge clk);
    start     = 1'b0;
    mode      = 2'($urandom);
    enable_in = 1'($urandom);
    wave_in   = 2'($urandom);
    freq_in   = {$urandom, $urandom};
    duty_in   = 16'($urandom);
    check_output("ready_low_after_accept", ready, 0);
    check_output("nack_clear_after_accept", nack, 0);
  endtask

  // Bus monitor + slave model, sampled on the falling clk edge.
  bit        prev_scl  = 1'b1;
  bit        prev_sda  = 1'b1;
  int        bit_pos   = 0;
  int        byte_cnt  = 0;
  logic [7:0] rx_byte  = 8'h00;
  bit        chk_ready = 1'b0;
  done_exp_t de;

  always @(negedge clk) begin
    if (!reset_n) begin
      bit_pos   = 0;
      byte_cnt  = 0;
      slave_low = 1'b0;
      chk_ready = 1'b0;
    end else begin
      if (prev_scl && scl && prev_sda && !sda_bus) begin
        expect_tok(TOK_START);
        bit_pos  = 0;
        byte_cnt = 0;
      end else if (prev_scl && scl && !prev_sda && sda_bus) begin
        expect_tok(TOK_STOP);
        bit_pos = 0;
      end else if (!prev_scl && scl) begin
        if (bit_pos < 8) begin
          rx_byte = {rx_byte[6:0], sda_bus};
          bit_pos++;
          if (bit_pos == 8) expect_tok(int'(rx_byte));
        end else begin
          bit_pos = 0;
          byte_cnt++;
        end
      end else if (prev_scl && !scl) begin
        if (bit_pos == 8 && byte_cnt != slave_nack_at) slave_low = 1'b1;
        else if (bit_pos == 0) slave_low = 1'b0;
      end
      if (chk_ready) begin
        check_output("ready_after_done", ready, 1);
        chk_ready = 1'b0;
      end
      if (done) begin
        if (done_q.size() == 0) begin
          report_missing("unexpected_done");
        end else begin
          de = done_q.pop_front();
          check_output("done_latency", cyc - de.accept_cyc, de.latency);
          check_output("nack_at_done", nack, de.nack);
        end
        check_output("ready_low_during_done", ready, 0);
        chk_ready = 1'b1;
      end
    end
    prev_scl = scl;
    prev_sda = sda_bus;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: actual=running required=finished");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (3) @(negedge clk);
    check_output("reset_scl", scl, 1);
    check_output("reset_sda", sda_bus, 1);
    check_output("reset_ready", ready, 1);
    check_output("reset_done", done, 0);
    check_output("reset_nack", nack, 0);
    reset_n = 1'b1;
    @(negedge clk);

    apply_stimulus(2'b00, 1'b1, 2'b10, 64'h0, 16'h0, -1);
    apply_stimulus(2'b01, 1'b0, 2'b00, 64'h0123456789ABCDEF, 16'h0, -1);
    apply_stimulus(2'b10, 1'b0, 2'b00, 64'h0, 16'h8000, -1);
    apply_stimulus(2'b00, 1'b1, 2'b01, 64'h0, 16'h0, 0);
    apply_stimulus(2'b11, 1'b1, 2'b11, 64'hFFFF_FFFF_FFFF_FFFF, 16'hFFFF, -1);
    apply_stimulus(2'b01, 1'b1, 2'b01, 64'hA5A5_0F0F_3C3C_9696, 16'h0, 4);
    apply_stimulus(2'b10, 1'b0, 2'b10, 64'h0, 16'h1234, 1);

    apply_stimulus(2'b10, 1'b1, 2'b00, 64'h0, 16'hA55A, -1);
    repeat (100) @(negedge clk);
    mode    = 2'b01;
    freq_in = 64'hDEAD_BEEF_DEAD_BEEF;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;

    apply_stimulus(2'b01, 1'b1, 2'b10, 64'hFEDCBA9876543210, 16'h0, -1);
    repeat (487) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check_output("async_reset_scl", scl, 1);
    check_output("async_reset_sda", sda_bus, 1);
    check_output("async_reset_ready", ready, 1);
    check_output("async_reset_done", done, 0);
    check_output("async_reset_nack", nack, 0);
    tok_q.delete();
    done_q.delete();
    last_nack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    apply_stimulus(2'b01, 1'b1, 2'b10, 64'h0F1E2D3C4B5A6978, 16'h0, -1);

    for (int k = 0; k < 14; k++) begin
      apply_stimulus(2'($urandom), 1'($urandom), 2'($urandom), {$urandom, $urandom},
                     16'($urandom),
                     ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 9)) : -1);
    end

    wait_ready();
    repeat (5) @(negedge clk);
    check_output("leftover_bus_tokens", tok_q.size(), 0);
    check_output("leftover_done_events", done_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/i2c_master_nco_writer.md
Name: i2c_master_nco_writer

Overview:
- I2C single-master write engine that programs the NCO's I2C slave register block: control byte, optional 64-bit frequency word, optional 16-bit duty-cycle word.
- Sits on the host/test side of the I2C bus and drives SCL and SDA.
- Produces exactly the frame the NCO slave decodes: START, address+W, control byte, data bytes MSB first, STOP.

Parameters:
- SLAVE_ADDR, 7'b1101010, 7-bit target address sent in the first byte.
- CLK_DIV, 16, clk cycles per quarter SCL period; one bit time = 4*CLK_DIV clk; legal range ≥2.

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- start  input  1  1-clk request; accepted only when ready=1
- mode  input  2  00 control only, 01 control+frequency, 10 control+duty, 11 treated as 00
- enable_in  input  1  NCO enable, goes to control bit 0
- wave_in  input  2  waveform select, goes to control bits 2:1
- freq_in  input  64  frequency word
- duty_in  input  16  duty-cycle word
- ready  output  1  idle, can accept start
- done  output  1  1-clk pulse when a frame finishes (ACKed or NACKed)
- nack  output  1  last frame was aborted by a NACK; held until next accepted start
- scl  output  1  I2C clock, push-pull; no clock stretching supported
- sda  inout  1  open-drain: driven 0 or released (z), never driven 1

Behaviour:
- Reset (async, reset_n=0): scl=1, sda released, ready=1, done=0, nack=0, state IDLE, all counters cleared. Reset mid-frame applies the same values immediately, with no STOP generated.
- Accept: start=1 while ready=1 latches all inputs in that clk, clears nack, and sets ready=0 next clk. start while ready=0 is ignored.
- Control byte = {3'b000, duty_flag, freq_flag, wave_in, enable_in}.
  - freq_flag=1 only for mode 01.
  - duty_flag=1 only for mode 10.
- Bit timing: each bit is 4 quarters Q0..Q3 of CLK_DIV clk each.
  - Q0, Q1: SCL=0. SDA is updated on the first clk of Q0.
  - Q2, Q3: SCL=1.
  - ACK is sampled on the last clk of Q2. Slave ACK = SDA low.
- States: IDLE, START, ADDR, ADDR_ACK, CTRL, CTRL_ACK, DATA, DATA_ACK, STOP.
  - IDLE→START on accepted start.
  - START (1 bit time): SCL=1 throughout, SDA released for Q0-Q1 and pulled low at Q2, then SCL goes low → ADDR.
  - ADDR: shifts out {SLAVE_ADDR, 1'b0} MSB first, 8 bits → ADDR_ACK. The master releases SDA for 1 bit time.
  - ADDR_ACK: ACK→CTRL; NACK→STOP with nack set.
  - CTRL: 8 bits → CTRL_ACK.
  - CTRL_ACK: NACK→STOP (nack). ACK→DATA if mode 01/10, else STOP.
  - DATA: frequency sends 8 bytes freq_in[63:56] first; duty sends 2 bytes duty_in[15:8] first; each byte MSB first → DATA_ACK.
  - DATA_ACK: NACK→STOP (nack). ACK with bytes remaining→DATA. ACK on the last byte→STOP.
  - STOP (1 bit time): SDA low with SCL=0 in Q0-Q1; SCL=1 from Q2; SDA released at Q3 → IDLE.
  - done pulses on the IDLE-entry clk; ready=1 on the following clk.
- Frame length in bit times (START + 9 per byte + STOP): mode 00 = 20, mode 01 = 92, mode 10 = 38.
- Counters: 3-bit bit counter counting 7→0; 4-bit byte counter; quarter counter width ceil(log2(CLK_DIV)). Data is held in a 64-bit shift register loaded at accept.

Optional Feature:
- Macro: I2C_NACK_RETRY_EN.
- Defined:
  - After a NACK-terminated STOP, the frame is restarted from START with the same latched data.
  - Up to 2 retries, separated by 1 idle bit time (SCL=1, SDA released).
  - done and nack are reported only after the final attempt; nack=1 only if all 3 attempts NACK.
  - A successful retry gives nack=0.
- Not defined: no retry; the NACK frame ends with done and nack=1.

Test Plan:
- CLK_DIV=4, mode 00, enable_in=1, wave_in=2'b10, slave model ACKs → bytes 0xD4, 0x05 on SDA; done after 320 clk from accept; nack=0.
- mode 01, freq_in=64'h0123456789ABCDEF, ACKs → bytes 0xD4, 0x08, 0x01, 0x23, 0x45, 0x67, 0x89, 0xAB, 0xCD, 0xEF, then STOP; total 92 bit times.
- mode 10, duty_in=16'h8000, ACKs → bytes 0xD4, 0x10, 0x80, 0x00, STOP; START/STOP edges checked with SCL high.
- No slave (SDA floats high) → NACK at ADDR_ACK, STOP follows, done pulse, nack=1. With I2C_NACK_RETRY_EN: 3 START conditions seen before done.
- start pulsed again mid-frame → ignored, frame bytes unchanged. Then reset_n low in the middle of a DATA byte → scl=1, sda=z, ready=1 asynchronously; next start produces a complete clean frame.
